pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/freeze sequencer for the 5-stage ARM pipeline.
- Drives the freeze and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Inputs it decides on: data hazards from the ID stage, taken branches from EX, and multi-cycle memory accesses in MEM.
- A small FSM holds the whole pipeline during slow memory transactions, with timeout. Saturating performance counters are exposed for debug.

---
 rtl/pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze sequencer for the 5-stage pipeline.
//
// Decides per cycle whether to hold or clear the PC, IF/ID, ID/EX, EX/MEM
// and MEM/WB registers. Sources: ID-stage data hazards, taken branches from
// EX and slow memory accesses in MEM. A two-state FSM (run / memory wait)
// freezes the whole pipeline during slow memory accesses and gives up after
// MEM_TIMEOUT-1 wait cycles, raising a sticky error.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   src1, src2, two_src ID-stage source registers; two_src qualifies src2
//   id_valid            ID stage holds a real instruction
//   ex_dest, ex_wb_en   EX destination and write-back enable
//   ex_mem_read         EX instruction is a load
//   mem_dest, mem_wb_en MEM destination and write-back enable
//   forward_en          forwarding unit enabled
//   branch_taken        taken branch resolved in EX
//   mem_req, mem_ready  MEM access request / completion
//   *_freeze, *_flush   pipeline register controls
//   mem_error           sticky memory timeout flag
//   stall_cnt           saturating count of hazard-stall cycles
//   flush_cnt           saturating count of branch-flush cycles
//   memwait_cnt         saturating count of memory-freeze cycles
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             id_valid,
  input  logic [3:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_freeze,
  output logic             id_ex_flush,
  output logic             ex_mem_freeze,
  output logic             mem_wb_flush,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  // Wait counter never exceeds MEM_TIMEOUT-1, so clog2 bits suffice.
  localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             freeze;
  logic             timeout;
  logic             match_ex, match_mem, hazard;
  logic             stall_evt, flush_evt;

  // Source-register matches against the EX and MEM destinations.
  always_comb begin
    match_ex  = id_valid & ((src1 == ex_dest)  | (two_src & (src2 == ex_dest)));
    match_mem = id_valid & ((src1 == mem_dest) | (two_src & (src2 == mem_dest)));
    // With forwarding only a load in EX cannot be bypassed in time.
    if (forward_en) begin
      hazard = ex_wb_en & ex_mem_read & match_ex;
    end else begin
      hazard = (ex_wb_en & match_ex) | (mem_wb_en & match_mem);
    end
  end

  // Memory-wait FSM: next state and freeze.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    freeze  = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_req && !mem_ready) begin
          freeze  = 1'b1;
          state_d = StMemWait;
          wait_d  = WaitW'(1);
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d = StRun;
          wait_d  = '0;
        end else if (wait_q < WaitLast) begin
          freeze = 1'b1;
          wait_d = wait_q + WaitW'(1);
        end else begin
          // Give up: release the pipeline and flag the error.
          timeout = 1'b1;
          state_d = StRun;
          wait_d  = '0;
        end
      end
      default: begin
        state_d = StRun;
        wait_d  = '0;
      end
    endcase
    if (rst) begin
      freeze  = 1'b0;
      timeout = 1'b0;
      state_d = StRun;
      wait_d  = '0;
    end
  end

  // Pipeline controls. Priority: reset, memory freeze, branch, hazard.
  always_comb begin
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_freeze  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_freeze = 1'b0;
    mem_wb_flush  = 1'b0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (freeze) begin
      pc_freeze     = 1'b1;
      if_id_freeze  = 1'b1;
      id_ex_freeze  = 1'b1;
      ex_mem_freeze = 1'b1;
      mem_wb_flush  = 1'b1;
    end else if (branch_taken) begin
      // Branch wins over a hazard so the PC loads the target.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_evt   = 1'b1;
    end else if (hazard) begin
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      id_ex_flush  = 1'b1;
      stall_evt    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      wait_q      <= '0;
      mem_error   <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (timeout) begin
        mem_error <= 1'b1;
      end
      if (stall_evt && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (freeze && (memwait_cnt != '1)) begin
        memwait_cnt <= memwait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors and counter
// values are queued when stimulus is applied and compared mid-cycle.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 8;
  localparam int unsigned CNT_W       = 4;

  // Control vector: {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze,
  //                  id_ex_flush, ex_mem_freeze, mem_wb_flush}
  localparam logic [6:0] C_IDLE   = 7'b000_0000;
  localparam logic [6:0] C_RST    = 7'b001_0101;
  localparam logic [6:0] C_STALL  = 7'b110_0100;
  localparam logic [6:0] C_BRANCH = 7'b001_0100;
  localparam logic [6:0] C_FREEZE = 7'b110_1011;

  logic clk;
  logic rst;
  logic [3:0] src1, src2, ex_dest, mem_dest;
  logic two_src, id_valid, ex_wb_en, ex_mem_read, mem_wb_en, forward_en;
  logic branch_taken, mem_req, mem_ready;
  logic pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush;
  logic ex_mem_freeze, mem_wb_flush, mem_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;

  typedef struct {
    string            tag;
    logic [6:0]       ctl;
    logic             err;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] fl;
    logic [CNT_W-1:0] mw;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   passed;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src1         (src1),
    .src2         (src2),
    .two_src      (two_src),
    .id_valid     (id_valid),
    .ex_dest      (ex_dest),
    .ex_wb_en     (ex_wb_en),
    .ex_mem_read  (ex_mem_read),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .forward_en   (forward_en),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_freeze    (pc_freeze),
    .if_id_freeze (if_id_freeze),
    .if_id_flush  (if_id_flush),
    .id_ex_freeze (id_ex_freeze),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_freeze(ex_mem_freeze),
    .mem_wb_flush (mem_wb_flush),
    .mem_error    (mem_error),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .memwait_cnt  (memwait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    src1 = 4'd0; src2 = 4'd0; two_src = 1'b0; id_valid = 1'b0;
    ex_dest = 4'd0; ex_wb_en = 1'b0; ex_mem_read = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; forward_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Load in EX writing r3, ID reads r3 through src1, forwarding enabled.
  task automatic load_use();
    forward_en = 1'b1; ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_dest = 4'd3;
    src1 = 4'd3; id_valid = 1'b1;
  endtask

  // Called one time unit after a rising edge with inputs already driven;
  // checks mid-cycle, then advances to one unit past the next rising edge.
  task automatic step(input string tag, input logic [6:0] ctl, input logic err,
                      input int st, input int fl, input int mw);
    exp_t e;
    logic [6:0] obs;
    e.tag = tag; e.ctl = ctl; e.err = err;
    e.st = CNT_W'(st); e.fl = CNT_W'(fl); e.mw = CNT_W'(mw);
    sb.push_back(e);
    #3;
    e = sb.pop_front();
    obs = {pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
           ex_mem_freeze, mem_wb_flush};
    total++;
    assert (obs === e.ctl) passed++;
    else $error("FAIL %s ctl: got %b want %b", e.tag, obs, e.ctl);
    total++;
    assert (mem_error === e.err) passed++;
    else $error("FAIL %s mem_error: got %b want %b", e.tag, mem_error, e.err);
    total++;
    assert (stall_cnt === e.st) passed++;
    else $error("FAIL %s stall_cnt: got %0d want %0d", e.tag, stall_cnt, e.st);
    total++;
    assert (flush_cnt === e.fl) passed++;
    else $error("FAIL %s flush_cnt: got %0d want %0d", e.tag, flush_cnt, e.fl);
    total++;
    assert (memwait_cnt === e.mw) passed++;
    else $error("FAIL %s memwait_cnt: got %0d want %0d", e.tag, memwait_cnt, e.mw);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    passed = 0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset_1", C_RST, 1'b0, 0, 0, 0);
    load_use();
    step("reset_2_hazard_masked", C_RST, 1'b0, 0, 0, 0);
    rst = 1'b0;
    idle_inputs();
    step("idle", C_IDLE, 1'b0, 0, 0, 0);

    load_use();
    step("load_use", C_STALL, 1'b0, 0, 0, 0);
    src1 = 4'd4; src2 = 4'd3; two_src = 1'b0;
    step("load_use_src2_unused", C_IDLE, 1'b0, 1, 0, 0);
    two_src = 1'b1;
    step("load_use_src2", C_STALL, 1'b0, 1, 0, 0);

    idle_inputs();
    mem_wb_en = 1'b1; mem_dest = 4'd5; two_src = 1'b1; src2 = 4'd5; id_valid = 1'b1;
    step("nofwd_mem_src2", C_STALL, 1'b0, 2, 0, 0);
    two_src = 1'b0;
    step("nofwd_src2_unused", C_IDLE, 1'b0, 3, 0, 0);
    two_src = 1'b1; forward_en = 1'b1;
    step("fwd_mem_bypassed", C_IDLE, 1'b0, 3, 0, 0);

    idle_inputs();
    load_use();
    id_valid = 1'b0;
    step("id_invalid", C_IDLE, 1'b0, 3, 0, 0);
    id_valid = 1'b1; branch_taken = 1'b1;
    step("branch_over_hazard", C_BRANCH, 1'b0, 3, 0, 0);
    idle_inputs();
    step("after_branch", C_IDLE, 1'b0, 3, 1, 0);

    // Slow access: four frozen cycles, branch and hazard masked meanwhile.
    mem_req = 1'b1;
    step("memwait_1", C_FREEZE, 1'b0, 3, 1, 0);
    load_use();
    branch_taken = 1'b1;
    step("memwait_2", C_FREEZE, 1'b0, 3, 1, 1);
    step("memwait_3", C_FREEZE, 1'b0, 3, 1, 2);
    step("memwait_4", C_FREEZE, 1'b0, 3, 1, 3);
    mem_ready = 1'b1;
    step("mem_ready_branch", C_BRANCH, 1'b0, 3, 1, 4);
    idle_inputs();
    step("after_memwait", C_IDLE, 1'b0, 3, 2, 4);
    mem_req = 1'b1; mem_ready = 1'b1;
    step("single_cycle_mem", C_IDLE, 1'b0, 3, 2, 4);

    // Timeout: MEM_TIMEOUT-1 frozen cycles, then release with error.
    mem_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step("timeout_freeze", C_FREEZE, 1'b0, 3, 2, 4 + i);
    end
    step("timeout_release", C_IDLE, 1'b0, 3, 2, 11);
    mem_req = 1'b0;
    step("post_timeout_run", C_IDLE, 1'b1, 3, 2, 11);
    step("error_sticky", C_IDLE, 1'b1, 3, 2, 11);

    // Reset while waiting on memory.
    mem_req = 1'b1;
    step("wait_before_rst", C_FREEZE, 1'b1, 3, 2, 11);
    rst = 1'b1;
    step("rst_mid_wait", C_RST, 1'b1, 3, 2, 12);
    rst = 1'b0;
    mem_req = 1'b0;
    step("after_rst_run", C_IDLE, 1'b0, 0, 0, 0);

    // Stall counter saturates at all-ones.
    load_use();
    for (int i = 0; i < 18; i++) begin
      step("stall_saturate", C_STALL, 1'b0, (i > 15) ? 15 : i, 0, 0);
    end
    idle_inputs();
    step("stall_saturated", C_IDLE, 1'b0, 15, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
